// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - single-cycle ALU with an iterative shift-add multiplier
module alu_seq_unit #(
    parameter int WIDTH     = 32,
    parameter int FAST_ZERO = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       function_bits,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, MUL} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_ILL
    } op_t;

    state_t          state;
    op_t             op;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             last_iter;

    always_comb begin
        op = OP_ILL;
        case (ALUOp)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (function_bits)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b101010: op = OP_SLT;
                    6'b011000: op = OP_MUL;
                    default:   op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    // Illegal encodings fall through to zero so the result register reads 0.
    always_comb begin
        alu_out = '0;
        case (op)
            OP_ADD:  alu_out = a + b;
            OP_SUB:  alu_out = a - b;
            OP_AND:  alu_out = a & b;
            OP_OR:   alu_out = a | b;
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_out = '0;
        endcase
    end

    assign acc_next  = acc + (mplier[0] ? mcand : '0);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            state  <= MUL;
                            busy   <= 1'b1;
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            result  <= alu_out;
                            zero    <= (FAST_ZERO != 0) && (alu_out == '0);
                            illegal <= (op == OP_ILL);
                            done    <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    // The final iteration's partial sum goes straight to result.
                    if (last_iter) begin
                        result  <= acc_next;
                        zero    <= (FAST_ZERO != 0) && (acc_next == '0);
                        illegal <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - scoreboard bench for alu_seq_unit (WIDTH=32 and WIDTH=8)
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic        busy, done, zero, illegal;
    logic [31:0] result;

    logic        start8;
    logic [7:0]  a8, b8, result8;
    logic        busy8, done8, zero8, illegal8;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        il;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(32), .FAST_ZERO(1)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOp(alu_op),
        .function_bits(funct), .a(a), .b(b), .busy(busy), .done(done),
        .result(result), .zero(zero), .illegal(illegal)
    );

    alu_seq_unit #(.WIDTH(8), .FAST_ZERO(0)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .ALUOp(2'b10),
        .function_bits(6'b011000), .a(a8), .b(b8), .busy(busy8), .done(done8),
        .result(result8), .zero(zero8), .illegal(illegal8)
    );

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                   input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic [63:0] p;
        e.il = 1'b0;
        e.r  = 32'h0;
        case (op)
            2'b00: e.r = x + y;
            2'b01: e.r = x - y;
            2'b10: begin
                case (f)
                    6'b100000: e.r = x + y;
                    6'b100010: e.r = x - y;
                    6'b100100: e.r = x & y;
                    6'b100101: e.r = x | y;
                    6'b101010: e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                    6'b011000: begin p = {32'h0, x} * {32'h0, y}; e.r = p[31:0]; end
                    default:   e.il = 1'b1;
                endcase
            end
            default: e.il = 1'b1;
        endcase
        e.z = (e.r == 32'h0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got done=1 want no pending request");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (result !== e.r || zero !== e.z || illegal !== e.il) begin
                    miscompares++;
                    $display("FAIL sb_result: got r=%h z=%b il=%b want r=%h z=%b il=%b",
                             result, zero, illegal, e.r, e.z, e.il);
                end
            end
        end
    end

    // Called at posedge+1; leaves at the following posedge+1 with start low.
    task automatic issue(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; alu_op = op; funct = f; a = x; b = y;
        sb.push_back(model(op, f, x, y));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; alu_op = 2'b00; funct = 6'h0; a = 32'd1; b = 32'd2;
        start8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, zero, illegal} !== 4'b0000 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state32: got b=%b d=%b z=%b il=%b r=%h want all 0",
                     busy, done, zero, illegal, result);
        end
        vectors++;
        if ({busy8, done8, zero8, illegal8} !== 4'b0000 || result8 !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_state8: got b=%b d=%b z=%b il=%b r=%h want all 0",
                     busy8, done8, zero8, illegal8, result8);
        end
        reset = 1'b0; start = 1'b0; start8 = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_start_discard: got done=%b busy8=%b want 0 0", done, busy8);
        end
    endtask

    task automatic test_sub;
        issue(2'b10, 6'b100010, 32'd5, 32'd7);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_timing: got done=%b busy=%b want 1 0", done, busy);
        end
    endtask

    task automatic test_slt;
        issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
        vectors++;
        if (result !== 32'd1) begin
            miscompares++;
            $display("FAIL slt_neg: got %h want 00000001", result);
        end
        issue(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF);
        vectors++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL slt_pos: got r=%h z=%b want 0 1", result, zero);
        end
    endtask

    task automatic test_random_ops;
        logic [5:0] flist [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        for (int i = 0; i < 16; i++) begin
            logic [1:0] op;
            logic [5:0] f;
            op = 2'($urandom_range(0, 3));
            f  = (i % 4 == 3) ? 6'($urandom_range(0, 63)) : flist[$urandom_range(0, 5)];
            if (f == 6'b011000) f = 6'b000000;
            issue(op, f, $urandom, (i % 5 == 0) ? 32'h0 : $urandom);
            vectors++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_timing[%0d]: got done=%b busy=%b want 1 0", i, done, busy);
            end
        end
    endtask

    task automatic test_illegal;
        issue(2'b11, 6'b100000, 32'd9, 32'd9);
        vectors++;
        if (illegal !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_flag: got il=%b r=%h z=%b want 1 0 1", illegal, result, zero);
        end
        issue(2'b00, 6'b000000, 32'd3, 32'd4);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (result !== 32'd7 || illegal !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_after_add: got r=%h il=%b d=%b want 7 0 0", result, illegal, done);
        end
    endtask

    task automatic test_mul32;
        int cyc;
        logic [31:0] x, y;
        x = $urandom; y = $urandom;
        issue(2'b10, 6'b011000, x, y);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            start = (cyc < 32); alu_op = 2'($urandom); funct = 6'($urandom);
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
        end
        start = 1'b0;
        vectors++;
        if (cyc != 32 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL mul32_latency: got busy_cycles=%0d done=%b want 32 1", cyc, done);
        end
    endtask

    task automatic test_mul8;
        logic [7:0] xs [2] = '{8'd13, 8'd16};
        logic [7:0] ys [2] = '{8'd11, 8'd16};
        logic [7:0] rs [2] = '{8'h8F, 8'h00};
        for (int k = 0; k < 2; k++) begin
            int cyc;
            start8 = 1'b1; a8 = xs[k]; b8 = ys[k];
            @(posedge clk); #1;
            cyc = 0;
            while (busy8 === 1'b1 && cyc < 100) begin
                cyc++;
                start8 = (cyc < 8); a8 = 8'($urandom); b8 = 8'($urandom);
                @(posedge clk); #1;
            end
            start8 = 1'b0;
            vectors++;
            if (cyc != 8 || done8 !== 1'b1 || result8 !== rs[k] || zero8 !== 1'b0 || illegal8 !== 1'b0) begin
                miscompares++;
                $display("FAIL mul8[%0d]: got cyc=%0d d=%b r=%h z=%b il=%b want 8 1 %h 0 0",
                         k, cyc, done8, result8, zero8, illegal8, rs[k]);
            end
            @(posedge clk); #1;
            vectors++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                miscompares++;
                $display("FAIL mul8_single_done[%0d]: got d=%b b=%b want 0 0", k, done8, busy8);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(2'b10, 6'b011000, 32'h0001_0000, 32'h0001_0000);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
        vectors++;
        if (done !== 1'b1 || zero !== 1'b1 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL b2b_mul: got d=%b z=%b r=%h want 1 1 0", done, zero, result);
        end
        issue(2'b00, 6'b000000, 32'd1, 32'd1);
        vectors++;
        if (done !== 1'b1 || result !== 32'd2) begin
            miscompares++;
            $display("FAIL b2b_add: got d=%b r=%h want 1 2", done, result);
        end
    endtask

    task automatic test_abort;
        start = 1'b1; alu_op = 2'b10; funct = 6'b011000; a = 32'd12345; b = 32'd678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy_before: got %b want 1", busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_state: got b=%b d=%b r=%h want 0 0 0", busy, done, result);
        end
        repeat (40) @(posedge clk);
        #1;
        issue(2'b00, 6'b000000, 32'd100, 32'd23);
        vectors++;
        if (done !== 1'b1 || result !== 32'd123) begin
            miscompares++;
            $display("FAIL abort_then_add: got d=%b r=%h want 1 7b", done, result);
        end
    endtask

    initial begin
        test_reset;
        test_sub;
        test_slt;
        test_random_ops;
        test_illegal;
        test_mul32;
        test_mul8;
        test_back_to_back;
        test_abort;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 Parameter FAST_ZERO, default 1, when 1 the zero flag is registered with result, when 0 zero is held at 0.
REQ-003 clk  input  1  rising-edge clock, sole clock of the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to execute one operation, sampled on rising clk edge.
REQ-006 ALUOp  input  2  operation class: 00 add, 01 subtract, 10 decode function_bits, 11 reserved.
REQ-007 function_bits  input  6  R-type funct field, used only when ALUOp=10.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 busy  output  1  high while a multi-cycle operation is in progress.
REQ-011 done  output  1  single-cycle pulse marking result/zero/illegal valid for a completed operation.
REQ-012 result  output  WIDTH  registered operation result.
REQ-013 zero  output  1  registered flag, result equals 0.
REQ-014 illegal  output  1  registered flag, last completed request had an undefined encoding.

Function
REQ-015 The block SHALL implement states IDLE and MUL only; start is accepted only in IDLE.
REQ-016 Decode SHALL be: ALUOp 00 ADD; 01 SUB; 10 with funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 011000 MUL; all other encodings, including ALUOp 11, illegal.
REQ-017 ADD/SUB SHALL be modulo 2^WIDTH; carry/borrow discarded.
REQ-018 SLT SHALL compare a and b as signed two's complement and return 1 (zero-extended) when a<b, else 0.
REQ-019 MUL SHALL return the low WIDTH bits of the unsigned product a*b.
REQ-020 Single-cycle ops (ADD, SUB, AND, OR, SLT): start sampled at edge N SHALL update result, zero and illegal=0 at edge N and assert done for exactly the cycle following edge N; busy stays 0.
REQ-021 Illegal encoding: start at edge N SHALL set result=0, zero=1 (if FAST_ZERO), illegal=1 and pulse done as in REQ-020.
REQ-022 MUL: start at edge N SHALL enter MUL, latch a and b, clear accumulator and iteration counter, and assert busy.
REQ-023 In MUL, each edge SHALL add the shifted multiplicand to the accumulator when the current multiplier LSB is 1, shift multiplicand left and multiplier right by one, and increment the counter.
REQ-024 At edge N+WIDTH the block SHALL load result from the accumulator, update zero, clear illegal, return to IDLE, deassert busy and assert done for the following cycle.
REQ-025 start, ALUOp, function_bits, a and b SHALL be ignored while busy=1; latched MUL operands SHALL not change.
REQ-026 A start sampled in the cycle where done=1 SHALL be accepted (back-to-back, no bubble).
REQ-027 result, zero and illegal SHALL hold their values between completions; done SHALL never be high for two consecutive cycles from one request.
REQ-028 Counter width SHALL be ceil(log2(WIDTH+1)) bits; no wrap-around occurs within a MUL.

Reset
REQ-029 While reset=1 at a rising edge the block SHALL enter IDLE with busy=0, done=0, result=0, zero=0, illegal=0, counter and accumulator cleared.
REQ-030 Reset SHALL take priority over start and over any in-progress MUL; an aborted MUL SHALL produce no done pulse.
REQ-031 start sampled at the same edge as reset=1 SHALL be discarded.

Verification
REQ-032 WIDTH=32, ALUOp=10, funct=100010, a=5, b=7, start one cycle -> next cycle done=1, result=0xFFFFFFFE, zero=0, illegal=0, busy=0.
REQ-033 WIDTH=32, ALUOp=10, funct=101010, a=0xFFFFFFFF, b=1 -> result=1; then a=1, b=0xFFFFFFFF -> result=0, zero=1.
REQ-034 WIDTH=8, MUL a=13, b=11 at edge N -> busy high for 8 cycles, done at cycle after edge N+8, result=0x8F (143); operand changes during busy have no effect.
REQ-035 WIDTH=32, ALUOp=11 start -> done next cycle, illegal=1, result=0; following ALUOp=00 a=3 b=4 -> result=7, illegal=0.
REQ-036 WIDTH=16, MUL a=0x0100 b=0x0100 -> result=0, zero=1; second start in the done cycle with ADD a=1 b=1 -> result=2 one cycle later.
REQ-037 WIDTH=32, MUL started, reset asserted after 10 cycles -> busy=0, done never pulses, result=0; subsequent ADD completes normally.
